piso_reader: RTL and testbench
==============================

# piso_reader

Reader for an external parallel-in/serial-out shift-register chain (74HC165-style) used to bring 8 push-buttons/switches onto the board. It generates the parallel-load and serial-clock strobes, samples the serial data line MSB-first, and presents the captured word with a one-cycle valid pulse. It sits beside the LED shift/rotate logic as the input-side counterpart: LEDs are shifted out, switches are shifted in. It runs on the system clock with an internal clock-enable instead of a derived clock.

## Interface
- WIDTH, 8: number of bits per scan (chain length).
- DIV, 4: system-clock cycles per half-period of SR_CLK and per load pulse; legal range ≥ 4.
- AUTO, 0: 1 = scan continuously and ignore START; 0 = one scan per START.

Ports:
- CLK  in  1  system clock; the block's only clock.
- RSTN  in  1  reset, asynchronous, active-low.
- START  in  1  request one scan; honoured only in IDLE, ignored when AUTO=1.
- SER_IN  in  1  serial data from the chain (QH); asynchronous to CLK.
- SR_LD_N  out  1  chain parallel-load, active-low.
- SR_CLK  out  1  chain shift clock; the chain shifts on its rising edge.
- DATA  out  WIDTH  last captured word; DATA[WIDTH-1] = first bit sampled.
- VALID  out  1  one-cycle pulse when DATA is updated.
- BUSY  out  1  high from LOAD entry until the cycle before VALID.

## Operation
- States: IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE.
- IDLE: SR_LD_N=1, SR_CLK=0, BUSY=0. START=1 (or AUTO=1) → LOAD on the next edge.
- LOAD: SR_LD_N=0 for exactly DIV cycles, BUSY=1, bit counter cleared → SHIFT_LO.
- SHIFT_LO: SR_CLK=0 for DIV cycles; on the last cycle the synchronized SER_IN is shifted into the LSB of the shift register (shift left) → SHIFT_HI.
- SHIFT_HI: SR_CLK=1 for DIV cycles; bit counter increments on exit; exit → SHIFT_LO if counter < WIDTH, else DONE.
- DONE: one cycle; DATA ← shift register, VALID=1, BUSY=0 → IDLE, or LOAD if AUTO=1.
- SER_IN passes through a 2-flop synchronizer; DIV ≥ 4 guarantees the synchronized value reflects the chain output settled after the preceding SR_CLK rise or load.
- DATA holds its value between scans; it changes only in DONE.
- START while BUSY=1 is ignored and not queued.
- Bit counter width is clog2(WIDTH+1); the phase counter counts 0..DIV-1 and wraps.

## Timing
- Reset values: SR_LD_N=1, SR_CLK=0, DATA=0, VALID=0, BUSY=0, state IDLE, counters 0, synchronizer flops 0.
- RSTN low mid-scan aborts immediately (async). Outputs take their reset values, and no VALID is produced for the aborted scan.
- START sampled high at edge 0 → SR_LD_N low on cycles 1..DIV.
- Bit k (k=0..WIDTH-1) is sampled on cycle DIV + 2·DIV·k + DIV.
- VALID is high on cycle 1 + DIV + 2·DIV·WIDTH (69 for the defaults).
- AUTO=1: LOAD of the next scan starts on the cycle after DONE; scan period is 1 + DIV + 2·DIV·WIDTH cycles. After reset release, the first LOAD starts on the first edge.
- SR_CLK and SR_LD_N are registered outputs, glitch-free, and never active simultaneously.

## Structure
- Shared package piso_pkg: state enum (IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE) and DIV_MIN = 4 constant. An elaboration check rejects DIV < DIV_MIN.
- Sub-module tick_gen: modulo-DIV phase counter producing a one-cycle `last` enable and restarting on each state change. The FSM, shift register and synchronizer live in piso_reader.

## Test plan
- Reset: hold RSTN=0 with START=1 → SR_LD_N=1, SR_CLK=0, DATA=0x00, VALID=0, BUSY=0 throughout.
- Single scan: chain model preloaded with 0xA5, START pulse at cycle 0 → SR_LD_N low for cycles 1–4, 8 SR_CLK rising edges, VALID on cycle 69 only, DATA=0xA5, BUSY low from cycle 69.
- Ignored START: pulse START at cycles 10 and 40 during a scan of 0x3C → exactly one VALID, DATA=0x3C, no extra SR_LD_N pulse.
- AUTO=1: chain values 0x01, 0xFF, 0x80 on successive scans → VALID every 69 cycles with DATA 0x01, 0xFF, 0x80 in order.
- Reset mid-scan: RSTN low at cycle 30, released at cycle 35, then START → no VALID before the new scan, outputs at reset values during reset, next DATA equals the chain value.
- Timing margin: DIV=4, chain model updates QH 3 cycles after each SR_CLK rise → every bit captured correctly for pattern 0x5A.

Source files
------------

// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and limits for the PISO chain reader
package piso_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } state_e;

  localparam int DIV_MIN = 4;

endpackage

// File: rtl/piso_reader_if.sv
// rtl/piso_reader_if.sv - chain strobes, serial input and captured-word handshake
interface piso_reader_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             ser_in;
  logic             sr_ld_n;
  logic             sr_clk;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             busy;

  modport master (
    input  start, ser_in,
    output sr_ld_n, sr_clk, data, valid, busy
  );

  modport slave (
    output start, ser_in,
    input  sr_ld_n, sr_clk, data, valid, busy
  );
endinterface

// File: rtl/piso_reader_tick_gen.sv
// rtl/piso_reader_tick_gen.sv - modulo-DIV phase counter with a one-cycle last enable
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic last
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || last) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/piso_reader.sv
// rtl/piso_reader.sv - scans an external 74HC165-style chain and presents the word MSB-first
module piso_reader
  import piso_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4,
  parameter bit AUTO  = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  piso_reader_if.master bus
);
  localparam int CW = $clog2(WIDTH + 1);

  if (DIV < DIV_MIN) begin : g_div_check
    $error("piso_reader: DIV must be at least DIV_MIN");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sync1_q, sync2_q;
  logic             sr_ld_n_q, sr_ld_n_d;
  logic             sr_clk_q, sr_clk_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             last;

  tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (state_d != state_q),
    .last    (last)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sreg_d    = sreg_q;
    data_d    = data_q;
    case (state_q)
      IDLE: begin
        if (AUTO || bus.start) state_d = LOAD;
      end
      LOAD: begin
        bit_cnt_d = '0;
        if (last) state_d = SHIFT_LO;
      end
      SHIFT_LO: begin
        // Sample at the end of the low phase, when QH has long settled
        if (last) begin
          sreg_d  = {sreg_q[WIDTH-2:0], sync2_q};
          state_d = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (last) begin
          bit_cnt_d = bit_cnt_q + CW'(1);
          state_d   = (bit_cnt_d < CW'(WIDTH)) ? SHIFT_LO : DONE;
        end
      end
      DONE: begin
        state_d = AUTO ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are registered from the next state so they align with state_q
    sr_ld_n_d = (state_d != LOAD);
    sr_clk_d  = (state_d == SHIFT_HI);
    valid_d   = (state_d == DONE);
    busy_d    = (state_d == LOAD) || (state_d == SHIFT_LO) || (state_d == SHIFT_HI);
    if (state_d == DONE) data_d = sreg_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sreg_q    <= '0;
      data_q    <= '0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sr_ld_n_q <= 1'b1;
      sr_clk_q  <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sreg_q    <= sreg_d;
      data_q    <= data_d;
      sync1_q   <= bus.ser_in;
      sync2_q   <= sync1_q;
      sr_ld_n_q <= sr_ld_n_d;
      sr_clk_q  <= sr_clk_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.sr_ld_n = sr_ld_n_q;
  assign bus.sr_clk  = sr_clk_q;
  assign bus.data    = data_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_piso_reader.sv
// tb/tb_piso_reader.sv - directed and randomized scans against a 74HC165 chain model
module tb_piso_reader;
  localparam int W     = 8;
  localparam int D     = 4;
  localparam int T_VAL = 1 + D + 2 * D * W;

  logic clk = 1'b0;
  logic rstn0 = 1'b0;
  logic rstn1 = 1'b0;
  always #5 clk = ~clk;

  piso_reader_if #(.WIDTH(W)) if0 ();
  piso_reader_if #(.WIDTH(W)) if1 ();

  piso_reader #(.WIDTH(W), .DIV(D), .AUTO(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rstn0), .bus(if0.master)
  );
  piso_reader #(.WIDTH(W), .DIV(D), .AUTO(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rstn1), .bus(if1.master)
  );

  int checks = 0;
  int failures = 0;
  int edges = 0;
  int e0 = 0;
  int e1 = 0;

  logic [7:0]  preset0 = 8'h00;
  logic [7:0]  chain0 = 8'h00;
  logic [7:0]  chain1 = 8'h00;
  logic        pclk0 = 1'b0;
  logic        pclk1 = 1'b0;
  logic [15:0] hist0 = 16'h0;
  int          qdelay = 0;
  logic [7:0]  auto_vals[$];
  int          auto_idx = 0;

  int         ld_cyc[$];
  int         val_cyc[$];
  int         val1_cyc[$];
  logic [7:0] val1_data[$];
  int         rises0 = 0;
  int         busy_first = -1;
  int         busy_last = -1;
  int         overlap = 0;

  always @(posedge clk) edges++;

  always @(negedge clk) begin
    int cyc;
    cyc = edges - e0 + 1;
    if (!if0.sr_ld_n) begin
      chain0 = preset0;
      ld_cyc.push_back(cyc);
    end else if (if0.sr_clk && !pclk0) begin
      chain0 = {chain0[6:0], 1'b0};
      rises0++;
    end
    pclk0 = if0.sr_clk;
    hist0 = {hist0[14:0], chain0[7]};
    if0.ser_in = hist0[qdelay];
    if (if0.busy) begin
      if (busy_first < 0) busy_first = cyc;
      busy_last = cyc;
    end
    if (!if0.sr_ld_n && if0.sr_clk) overlap++;
    if (if0.valid) val_cyc.push_back(cyc);

    if (!if1.sr_ld_n) begin
      chain1 = (auto_idx < auto_vals.size()) ? auto_vals[auto_idx] : 8'h00;
    end else if (if1.sr_clk && !pclk1) begin
      chain1 = {chain1[6:0], 1'b0};
    end
    pclk1 = if1.sr_clk;
    if1.ser_in = chain1[7];
    if (!if1.sr_ld_n && if1.sr_clk) overlap++;
    if (if1.valid) begin
      val1_cyc.push_back(edges - e1 + 1);
      val1_data.push_back(if1.data);
      auto_idx++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    ld_cyc.delete();
    val_cyc.delete();
    rises0 = 0;
    busy_first = -1;
    busy_last = -1;
  endtask

  task automatic do_start();
    @(negedge clk);
    clear_mon();
    if0.start = 1'b1;
    @(posedge clk);
    #1;
    e0 = edges;
    if0.start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ld_n"},  {31'd0, if0.sr_ld_n}, 32'd1);
    check({tag, "_sclk"},  {31'd0, if0.sr_clk},  32'd0);
    check({tag, "_data"},  {24'd0, if0.data},    32'd0);
    check({tag, "_valid"}, {31'd0, if0.valid},   32'd0);
    check({tag, "_busy"},  {31'd0, if0.busy},    32'd0);
  endtask

  task automatic run_scan(input logic [7:0] pat, input int dly, input string tag);
    preset0 = pat;
    qdelay = dly;
    do_start();
    repeat (T_VAL + 12) @(negedge clk);
    check({tag, "_nvalid"},  val_cyc.size(), 32'd1);
    check({tag, "_vcyc"},    (val_cyc.size() > 0) ? val_cyc[0] : -1, T_VAL);
    check({tag, "_data"},    {24'd0, if0.data}, {24'd0, pat});
    check({tag, "_nld"},     ld_cyc.size(), D);
    check({tag, "_ld0"},     (ld_cyc.size() > 0) ? ld_cyc[0] : -1, 32'd1);
    check({tag, "_ldn"},     (ld_cyc.size() > 0) ? ld_cyc[ld_cyc.size()-1] : -1, D);
    check({tag, "_rises"},   rises0, W);
    check({tag, "_bfirst"},  busy_first, 32'd1);
    check({tag, "_blast"},   busy_last, T_VAL - 1);
  endtask

  initial begin
    logic [7:0] pat;
    if0.start = 1'b1;
    if1.start = 1'b0;
    auto_vals.push_back(8'h01);
    auto_vals.push_back(8'hFF);
    auto_vals.push_back(8'h80);

    repeat (5) begin
      @(negedge clk);
      check_reset_outputs("rst");
      check("rst1_data", {24'd0, if1.data}, 32'd0);
      check("rst1_ld_n", {31'd0, if1.sr_ld_n}, 32'd1);
    end
    @(negedge clk);
    if0.start = 1'b0;
    rstn0 = 1'b1;
    repeat (3) @(negedge clk);

    run_scan(8'hA5, 0, "single");

    preset0 = 8'h3C;
    qdelay = 0;
    do_start();
    repeat (9) @(negedge clk);
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (29) @(negedge clk);
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (100) @(negedge clk);
    check("ign_nvalid", val_cyc.size(), 32'd1);
    check("ign_data", {24'd0, if0.data}, 32'h3C);
    check("ign_nld", ld_cyc.size(), D);

    preset0 = 8'h96;
    do_start();
    repeat (29) @(negedge clk);
    rstn0 = 1'b0;
    clear_mon();
    #1;
    check_reset_outputs("midrst");
    repeat (4) begin
      @(negedge clk);
      check_reset_outputs("midrst_hold");
    end
    @(negedge clk);
    rstn0 = 1'b1;
    repeat (40) @(negedge clk);
    check("midrst_novalid", val_cyc.size(), 32'd0);
    check("midrst_noload", ld_cyc.size(), 32'd0);
    run_scan(8'h69, 0, "after_rst");

    run_scan(8'h5A, 3, "margin");

    for (int i = 0; i < 4; i++) begin
      pat = 8'($urandom_range(0, 255));
      run_scan(pat, $urandom_range(0, 3), "rand");
    end

    @(negedge clk);
    rstn1 = 1'b1;
    @(posedge clk);
    #1;
    e1 = edges;
    repeat (3 * T_VAL + 10) @(negedge clk);
    check("auto_nvalid", val1_cyc.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("auto_vcyc", (val1_cyc.size() > i) ? val1_cyc[i] : -1, T_VAL * (i + 1));
      check("auto_data", (val1_data.size() > i) ? {24'd0, val1_data[i]} : 32'hFFFF_FFFF,
            {24'd0, auto_vals[i]});
    end

    check("no_overlap", overlap, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
